// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide sequencer and its arithmetic core.
package md_pkg;

  // Operation codes presented on md_opE by the E stage.
  typedef enum logic [2:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    DIV   = 3'd2,
    DIVU  = 3'd3,
    MTHI  = 3'd4,
    MTLO  = 3'd5
  } md_op_t;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } md_state_t;

  // Busy-window counter width; MULT_CYCLES and DIV_CYCLES must fit in it (max 15).
  localparam int CNT_W = 4;

  // True for the ops that open a multi-cycle busy window.
  function automatic logic is_long_op(input logic [2:0] op);
    return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational HI/LO result for the latched mult/div operation.
// Signed division runs on magnitudes so 0x80000000 / -1 cannot overflow:
// its quotient magnitude 0x80000000 keeps its bit pattern when left positive.
module md_arith
  import md_pkg::*;
(
  input  md_op_t      i_op,
  input  logic [31:0] i_rs,
  input  logic [31:0] i_rt,
  output logic [31:0] o_hi_next,
  output logic [31:0] o_lo_next,
  output logic        o_div_by_zero
);

  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic        w_signed_div;
  logic        w_rs_neg;
  logic        w_rt_neg;
  logic [31:0] w_rs_mag;
  logic [31:0] w_rt_mag;
  logic [31:0] w_den;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_q;
  logic [31:0] w_r;

  assign w_prod_s = $signed({{32{i_rs[31]}}, i_rs}) * $signed({{32{i_rt[31]}}, i_rt});
  assign w_prod_u = {32'd0, i_rs} * {32'd0, i_rt};

  assign w_signed_div  = (i_op == DIV);
  assign w_rs_neg      = w_signed_div & i_rs[31];
  assign w_rt_neg      = w_signed_div & i_rt[31];
  assign w_rs_mag      = w_rs_neg ? (~i_rs + 32'd1) : i_rs;
  assign w_rt_mag      = w_rt_neg ? (~i_rt + 32'd1) : i_rt;
  assign o_div_by_zero = (i_rt == 32'd0);
  // Keep the divider defined on a zero divisor; the result is discarded anyway.
  assign w_den         = o_div_by_zero ? 32'd1 : w_rt_mag;
  assign w_q_mag       = w_rs_mag / w_den;
  assign w_r_mag       = w_rs_mag % w_den;
  assign w_q           = (w_rs_neg ^ w_rt_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
  assign w_r           = w_rs_neg ? (~w_r_mag + 32'd1) : w_r_mag;

  // Select the {hi, lo} pair for the latched op.
  always_comb begin
    o_hi_next = 32'd0;
    o_lo_next = 32'd0;
    case (i_op)
      MULT:      {o_hi_next, o_lo_next} = w_prod_s;
      MULTU:     {o_hi_next, o_lo_next} = w_prod_u;
      DIV, DIVU: begin
        o_hi_next = w_r;
        o_lo_next = w_q;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// HI/LO multiply/divide sequencer: fixed-latency busy window per op, result
// committed on the last busy edge, D-stage stall while the unit is occupied.
// Handshake: an op is accepted when startE is high in IDLE at a clock edge;
// startE while busy is illegal (md_stallD holds the issuing instruction).
module md_sequencer
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        startE,
  input  logic [2:0]  md_opE,
  input  logic [31:0] rsE,
  input  logic [31:0] rtE,
  input  logic        md_useD,
  output logic        busy,
  output logic        md_stallD,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_t        r_state;
  md_state_t        w_state_next;
  logic [CNT_W-1:0] r_cnt;
  md_op_t           r_op;
  logic [31:0]      r_rs;
  logic [31:0]      r_rt;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;

  logic             w_idle;
  logic             w_load_mul;
  logic             w_load_div;
  logic             w_write_hi;
  logic             w_write_lo;
  logic             w_last;
  logic             w_commit;
  logic [31:0]      w_hi_next;
  logic [31:0]      w_lo_next;
  logic             w_div_by_zero;

  md_arith u_arith (
    .i_op          (r_op),
    .i_rs          (r_rs),
    .i_rt          (r_rt),
    .o_hi_next     (w_hi_next),
    .o_lo_next     (w_lo_next),
    .o_div_by_zero (w_div_by_zero)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Next state: enter MUL/DIV on an accepted long op, leave on the last count.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_load_mul)      w_state_next = ST_MUL;
        else if (w_load_div) w_state_next = ST_DIV;
      end
      ST_MUL, ST_DIV: if (w_last) w_state_next = ST_IDLE;
      default:        w_state_next = ST_IDLE;
    endcase
  end

  // Outputs and datapath controls decoded from state and E-stage inputs.
  always_comb begin
    w_idle     = (r_state == ST_IDLE);
    busy       = !w_idle;
    w_load_mul = w_idle & startE & ((md_opE == MULT) || (md_opE == MULTU));
    w_load_div = w_idle & startE & ((md_opE == DIV)  || (md_opE == DIVU));
    w_write_hi = w_idle & startE & (md_opE == MTHI);
    w_write_lo = w_idle & startE & (md_opE == MTLO);
    w_last     = busy & (r_cnt == CNT_W'(1));
    w_commit   = w_last & !(w_div_by_zero & (r_state == ST_DIV));
    md_stallD  = md_useD & (busy | (startE & is_long_op(md_opE)));
  end

  // Busy-window down-counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_cnt <= '0;
    else if (w_load_mul) r_cnt <= CNT_W'(MULT_CYCLES);
    else if (w_load_div) r_cnt <= CNT_W'(DIV_CYCLES);
    else if (busy)       r_cnt <= r_cnt - CNT_W'(1);
  end

  // Operand and op latches, captured once at accept so E can move on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op <= MULT;
      r_rs <= '0;
      r_rt <= '0;
    end else if (w_load_mul | w_load_div) begin
      r_op <= md_op_t'(md_opE);
      r_rs <= rsE;
      r_rt <= rtE;
    end
  end

  // HI/LO registers: result commit at window end, or direct mthi/mtlo write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_commit) begin
      r_hi <= w_hi_next;
      r_lo <= w_lo_next;
    end else begin
      if (w_write_hi) r_hi <= rsE;
      if (w_write_lo) r_lo <= rsE;
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer: an architectural HI/LO model checked every
// cycle, plus literal expectations from hand-computed arithmetic.
module tb_md_sequencer;

  localparam int NMUL = 5;
  localparam int NDIV = 10;
  localparam logic [2:0] OP_MULT = 3'd0, OP_MULTU = 3'd1, OP_DIV = 3'd2,
                         OP_DIVU = 3'd3, OP_MTHI = 3'd4, OP_MTLO = 3'd5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        startE = 1'b0;
  logic [2:0]  md_opE = 3'd0;
  logic [31:0] rsE = 32'd0;
  logic [31:0] rtE = 32'd0;
  logic        md_useD = 1'b0;
  logic        busy;
  logic        md_stallD;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_pass   = 0;

  md_sequencer #(.MULT_CYCLES(NMUL), .DIV_CYCLES(NDIV)) dut (
    .clk(clk), .rst_n(rst_n), .startE(startE), .md_opE(md_opE),
    .rsE(rsE), .rtE(rtE), .md_useD(md_useD),
    .busy(busy), .md_stallD(md_stallD), .hi(hi), .lo(lo)
  );

  // Clock.
  always #5 clk = ~clk;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  // Architectural model: cycles left in the window and the pending result.
  int          m_left = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [31:0] m_pend_hi = 32'd0;
  logic [31:0] m_pend_lo = 32'd0;
  logic        m_pend_ok = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    longint      p;
    logic [63:0] pu;
    int          a, b;
    if (!rst_n) begin
      m_left = 0; m_hi = 0; m_lo = 0; m_pend_ok = 0;
    end else if (m_left > 0) begin
      if (startE) $display("FAIL illegal_start_while_busy: got 1 expected 0");
      m_left--;
      if (m_left == 0 && m_pend_ok) begin
        m_hi = m_pend_hi;
        m_lo = m_pend_lo;
      end
    end else if (startE) begin
      a = rsE;
      b = rtE;
      case (md_opE)
        OP_MULT: begin
          p = longint'(a) * longint'(b);
          {m_pend_hi, m_pend_lo} = p;
          m_pend_ok = 1; m_left = NMUL;
        end
        OP_MULTU: begin
          pu = {32'd0, rsE} * {32'd0, rtE};
          {m_pend_hi, m_pend_lo} = pu;
          m_pend_ok = 1; m_left = NMUL;
        end
        OP_DIV: begin
          m_left = NDIV;
          m_pend_ok = (b != 0);
          if (rsE == 32'h8000_0000 && rtE == 32'hFFFF_FFFF) begin
            m_pend_lo = 32'h8000_0000; m_pend_hi = 32'd0;
          end else if (b != 0) begin
            m_pend_lo = a / b; m_pend_hi = a % b;
          end
        end
        OP_DIVU: begin
          m_left = NDIV;
          m_pend_ok = (rtE != 0);
          if (rtE != 0) begin
            m_pend_lo = rsE / rtE; m_pend_hi = rsE % rtE;
          end
        end
        OP_MTHI: m_hi = rsE;
        OP_MTLO: m_lo = rsE;
        default: ;
      endcase
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic exp_stall;
    exp_stall = md_useD & ((m_left > 0) | (startE & (md_opE <= OP_DIVU)));
    check("cyc_busy",  {31'd0, busy},      {31'd0, m_left > 0});
    check("cyc_stall", {31'd0, md_stallD}, {31'd0, exp_stall});
    check("cyc_hi", hi, m_hi);
    check("cyc_lo", lo, m_lo);
  end

  // Present one op for one edge, then scramble operands to prove they were latched.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    startE = 1'b1; md_opE = op; rsE = a; rtE = b;
    @(posedge clk); #1;
    startE = 1'b0;
    rsE = $urandom(); rtE = $urandom();
    md_opE = 3'($urandom_range(0, 7));
  endtask

  // Count cycles busy stays high, sampled 1 after each edge; bounded.
  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++; @(posedge clk); #1;
    end
  endtask

  task automatic count_stall(output int n);
    n = 0;
    while (md_stallD === 1'b1 && n < 40) begin
      n++; @(posedge clk); #1;
    end
  endtask

  task automatic long_op(input string name, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b, input int n_exp,
                         input logic [31:0] hi_exp, input logic [31:0] lo_exp);
    int n;
    issue(op, a, b);
    count_busy(n);
    check({name, "_busy_cycles"}, 32'(n), 32'(n_exp));
    check({name, "_hi"}, hi, hi_exp);
    check({name, "_lo"}, lo, lo_exp);
    check({name, "_model_hi"}, m_hi, hi_exp);
    check({name, "_model_lo"}, m_lo, lo_exp);
  endtask

  initial begin
    int n;
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    md_useD = 1'b1; startE = 1'b1; md_opE = OP_DIV; #1;
    check("reset_stall_comb", {31'd0, md_stallD}, 32'd1);
    md_useD = 1'b0; startE = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    long_op("mult",  OP_MULT,  32'hFFFF_FFFE, 32'd3, NMUL, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    long_op("multu", OP_MULTU, 32'hFFFF_FFFE, 32'd3, NMUL, 32'h0000_0002, 32'hFFFF_FFFA);
    long_op("div",   OP_DIV,   32'hFFFF_FFF9, 32'd2, NDIV, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    long_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, NDIV, 32'd0, 32'h8000_0000);
    long_op("divu",  OP_DIVU,  32'd100, 32'd7, NDIV, 32'd2, 32'd14);

    // Preload, then divide by zero: window still runs, HI/LO untouched.
    issue(OP_MTHI, 32'h11, 32'd0);
    issue(OP_MTLO, 32'h22, 32'd0);
    check("mt_no_busy", {31'd0, busy}, 32'd0);
    long_op("divu_zero", OP_DIVU, 32'd5, 32'd0, NDIV, 32'h11, 32'h22);

    // Undefined op code is ignored.
    issue(3'd6, 32'hDEAD_BEEF, 32'd1);
    check("undef_busy", {31'd0, busy}, 32'd0);
    check("undef_hi", hi, 32'h11);

    // mflo in D the cycle after a mult start: stalled exactly NMUL cycles.
    issue(OP_MULT, 32'd7, 32'd9);
    md_useD = 1'b1; #1;
    count_stall(n);
    check("stall_cycles", 32'(n), 32'(NMUL));
    check("stall_release_busy", {31'd0, busy}, 32'd0);
    check("stall_release_lo", lo, 32'd63);
    check("stall_release_hi", hi, 32'd0);
    // mthi with md_useD in IDLE does not stall and lands next cycle.
    startE = 1'b1; md_opE = OP_MTHI; rsE = 32'hABCD; #1;
    check("mthi_no_stall", {31'd0, md_stallD}, 32'd0);
    @(posedge clk); #1;
    startE = 1'b0; md_useD = 1'b0;
    check("mthi_hi", hi, 32'hABCD);
    check("mthi_busy", {31'd0, busy}, 32'd0);

    // Reset during busy cycle 4 of a div aborts it and clears HI/LO at once.
    issue(OP_DIV, 32'd100, 32'd7);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    long_op("mult_after_reset", OP_MULT, 32'd6, 32'd7, NMUL, 32'd0, 32'd42);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
